// File: rtl/inst_fetch_if.sv
// ============================================================================
// Module      : inst_fetch_if
// Description : Instruction BRAM read port between the fetch stage and memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface inst_fetch_if #(
    parameter int AW = 10
);
    logic [AW-1:0] mem_addr;
    logic          mem_en;
    logic [31:0]   mem_dout;

    modport master (
        output mem_addr,
        output mem_en,
        input  mem_dout
    );

    modport slave (
        input  mem_addr,
        input  mem_en,
        output mem_dout
    );
endinterface

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
// Module      : inst_fetch
// Description : RV32I fetch stage: PC, BRAM read, IF/ID register, stall,
//               redirect and sticky fault. FETCH_PERF_CNT_EN adds counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch #(
    parameter int          INST_DEPTH = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    inst_fetch_if.master     bus,
    input  wire logic        stall,
    input  wire logic        redirect_valid,
    input  wire logic [31:0] redirect_pc,
    output logic             if_id_valid,
    output logic [31:0]      if_id_inst,
    output logic [31:0]      if_id_pc,
    output logic             fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      fetch_cnt,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
`endif
);

    localparam int          AW          = $clog2(INST_DEPTH);
    localparam logic [31:0] c_LAST_PC   = 32'(INST_DEPTH - 4);

    localparam logic [1:0]  c_ST_BOOT   = 2'd0;
    localparam logic [1:0]  c_ST_RUN    = 2'd1;
    localparam logic [1:0]  c_ST_FAULT  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic        w_redir_bad;
    logic        w_at_end;

    assign bus.mem_addr = r_pc[AW-1:0];
    assign bus.mem_en   = (r_state == c_ST_RUN);

    // Full 32-bit compares so stray upper bits fault instead of aliasing.
    assign w_next_pc   = r_pc + 32'd4;
    assign w_redir_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc > c_LAST_PC);
    assign w_at_end    = (w_next_pc > c_LAST_PC);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_BOOT;
            r_pc        <= RESET_PC;
            if_id_valid <= 1'b0;
            if_id_inst  <= 32'h0;
            if_id_pc    <= 32'h0;
            fault       <= 1'b0;
        end else begin
            case (r_state)
                c_ST_BOOT: begin
                    r_state <= c_ST_RUN;
                end
                c_ST_RUN: begin
                    if (redirect_valid) begin
                        if_id_valid <= 1'b0;
                        r_pc        <= redirect_pc;
                        if (w_redir_bad) begin
                            r_state <= c_ST_FAULT;
                            fault   <= 1'b1;
                        end
                    end else if (!stall) begin
                        if_id_inst  <= bus.mem_dout;
                        if_id_pc    <= r_pc;
                        if_id_valid <= 1'b1;
                        // Last word is still delivered; PC never wraps to 0.
                        if (w_at_end) begin
                            r_state <= c_ST_FAULT;
                            fault   <= 1'b1;
                        end else begin
                            r_pc <= w_next_pc;
                        end
                    end
                end
                c_ST_FAULT: begin
                    if_id_valid <= 1'b0;
                    fault       <= 1'b1;
                end
                default: begin
                    r_state <= c_ST_BOOT;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic w_cnt_fetch;
    logic w_cnt_stall;
    logic w_cnt_flush;

    always_comb begin
        w_cnt_fetch = 1'b0;
        w_cnt_stall = 1'b0;
        w_cnt_flush = 1'b0;
        if (r_state == c_ST_RUN) begin
            w_cnt_flush = redirect_valid;
            w_cnt_stall = !redirect_valid && stall;
            w_cnt_fetch = !redirect_valid && !stall;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= 32'h0;
            stall_cnt <= 32'h0;
            flush_cnt <= 32'h0;
        end else begin
            if (w_cnt_fetch && (fetch_cnt != 32'hFFFF_FFFF)) fetch_cnt <= fetch_cnt + 32'd1;
            if (w_cnt_stall && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
            if (w_cnt_flush && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`else
    // Counters absent; fetch path is identical.
`endif

endmodule

`default_nettype wire
